// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory arbiter and its BRAM port.
// The response tag carries a granted request through the 2-stage response pipeline.
package data_mem_pkg;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 64;
  localparam int WORD_BYTES   = 8;
  localparam int WORD_IDX_LSB = 3;
  localparam int WORD_IDX_MSB = 11;
  localparam int MEM_BYTES    = 4096;
  localparam int ID_W         = 3;   // wide enough for up to 8 requesters

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            is_load;
    logic            err;
  } resp_tag_t;

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return addr[WORD_IDX_LSB-1:0] != '0;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr.sv
// Generic N-way round-robin arbiter: grants the first requester at or above ptr
// (modulo N); ptr moves just past the winner when the update enable is high.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic             upd_en_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_any_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   cand;

  always_comb begin
    grant_any_o = 1'b0;
    grant_idx_o = '0;
    cand        = '0;
    for (int i = 0; i < N; i++) begin
      // one spare bit so the sum never overflows before the modulo fold
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!grant_any_o && req_i[cand[IDX_W-1:0]]) begin
        grant_any_o = 1'b1;
        grant_idx_o = cand[IDX_W-1:0];
      end
    end
    grant_o = grant_any_o ? (N'(1) << grant_idx_o) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_en_i && grant_any_o)
      ptr_d = (grant_idx_o == IDX_W'(N-1)) ? '0 : grant_idx_o + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one 64-bit BRAM (load + store port, 1-cycle read) among NUM_REQ requesters;
// checks alignment/range and returns tagged responses exactly two cycles after grant.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_LIMIT = MEM_BYTES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic                      resp_err,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      mem_ld_en,
  output logic [ADDR_W-1:0]         mem_ld_addr,
  input  logic [DATA_W-1:0]         mem_ld_data,
  output logic                      mem_st_en,
  output logic [ADDR_W-1:0]         mem_st_addr,
  output logic [DATA_W-1:0]         mem_st_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;

  // masking requests under reset keeps ready, the BRAM ports and ptr quiet
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_valid & {NUM_REQ{~rst}}),
    .upd_en_i    (~rst),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  assign req_ready = grant;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              req_err;
  logic              acc_ok;

  assign sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
  assign sel_we    = req_we[grant_idx];
  assign req_err   = is_misaligned(sel_addr) || (sel_addr >= ADDR_W'(ADDR_LIMIT));
  assign acc_ok    = grant_any && !req_err;

  always_comb begin
    mem_ld_en   = 1'b0;
    mem_ld_addr = '0;
    mem_st_en   = 1'b0;
    mem_st_addr = '0;
    mem_st_data = '0;
    if (acc_ok && !sel_we) begin
      mem_ld_en   = 1'b1;
      mem_ld_addr = sel_addr;
    end
    if (acc_ok && sel_we) begin
      mem_st_en   = 1'b1;
      mem_st_addr = sel_addr;
      mem_st_data = sel_wdata;
    end
  end

  resp_tag_t          s1_q, s1_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [DATA_W-1:0]  resp_data_q, resp_data_d;

  always_comb begin
    s1_d = '0;
    if (grant_any) begin
      s1_d.valid   = 1'b1;
      s1_d.id      = ID_W'(grant_idx);
      s1_d.is_load = !sel_we;
      s1_d.err     = req_err;
    end
    resp_valid_d = s1_q.valid ? (NUM_REQ'(1) << s1_q.id) : '0;
    resp_err_d   = s1_q.valid && s1_q.err;
    // BRAM read data lands during the cycle after the grant, aligned with stage 1
    resp_data_d  = (s1_q.valid && s1_q.is_load && !s1_q.err) ? mem_ld_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      s1_q         <= s1_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // responses read as idle for the whole time reset is held
  assign resp_valid = resp_valid_q & {NUM_REQ{~rst}};
  assign resp_err   = resp_err_q & ~rst;
  assign resp_data  = resp_data_q & {DATA_W{~rst}};

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: BRAM model, arbitration table, directed corner
// sequences and randomized traffic checked against a cycle-level reference model.
module tb_data_mem_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_we, req_ready, resp_valid;
  logic [N*32-1:0] req_addr;
  logic [N*64-1:0] req_wdata;
  logic           resp_err;
  logic [63:0]    resp_data;
  logic           mem_ld_en, mem_st_en;
  logic [31:0]    mem_ld_addr, mem_st_addr;
  logic [63:0]    mem_ld_data, mem_st_data;

  always #5 clk = ~clk;

  data_mem_arbiter #(.NUM_REQ(N), .ADDR_LIMIT(4096)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err), .resp_data(resp_data),
    .mem_ld_en(mem_ld_en), .mem_ld_addr(mem_ld_addr), .mem_ld_data(mem_ld_data),
    .mem_st_en(mem_st_en), .mem_st_addr(mem_st_addr), .mem_st_data(mem_st_data)
  );

  logic [63:0] bram [512];
  logic [63:0] bram_rd = '0;
  always @(posedge clk) begin
    if (mem_st_en) bram[mem_st_addr[11:3]] <= mem_st_data;
    if (mem_ld_en) bram_rd <= bram[mem_ld_addr[11:3]];
  end
  assign mem_ld_data = bram_rd;

  // requester-side state
  bit          v [N];
  bit          w [N];
  logic [31:0] a [N];
  logic [63:0] d [N];

  // reference model
  typedef struct { bit vld; int id; bit err; logic [63:0] data; } rsp_t;
  logic [63:0] gold [512];
  int   ptr_m;
  int   last_g;
  rsp_t p1, p2;

  int n_chk = 0;
  int n_err = 0;

  typedef struct { logic [3:0] valid; logic [3:0] exp_ready; } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = v[i];
      req_we[i]             = w[i];
      req_addr[32*i +: 32]  = a[i];
      req_wdata[64*i +: 64] = d[i];
    end
  endtask

  task automatic clear_model();
    ptr_m  = 0;
    last_g = -1;
    p1 = '{vld: 0, id: 0, err: 0, data: '0};
    p2 = '{vld: 0, id: 0, err: 0, data: '0};
  endtask

  // Drive inputs, then at the falling edge compare every output with the model.
  task automatic sample();
    int g;
    bit e, eld, est;
    logic [63:0] rdat;
    int widx;
    drive();
    @(negedge clk);
    g = -1; e = 0; eld = 0; est = 0; rdat = '0; widx = 0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr_m + k) % N;
        if (g < 0 && v[c]) g = c;
      end
    end
    if (g >= 0) begin
      e    = (a[g] % 8 != 0) || (a[g] >= 4096);
      eld  = !e && !w[g];
      est  = !e && w[g];
      widx = int'(a[g] / 8) % 512;
      if (eld) rdat = gold[widx];
    end
    chk("ready",   {60'd0, req_ready}, (g >= 0) ? 64'(1 << g) : 64'd0);
    chk("ld_en",   {63'd0, mem_ld_en}, {63'd0, eld});
    chk("ld_addr", {32'd0, mem_ld_addr}, eld ? {32'd0, a[g]} : 64'd0);
    chk("st_en",   {63'd0, mem_st_en}, {63'd0, est});
    chk("st_addr", {32'd0, mem_st_addr}, est ? {32'd0, a[g]} : 64'd0);
    chk("st_data", mem_st_data, est ? d[g] : 64'd0);
    chk("resp_valid", {60'd0, resp_valid}, (!rst && p2.vld) ? 64'(1 << p2.id) : 64'd0);
    chk("resp_err",   {63'd0, resp_err}, {63'd0, (!rst && p2.vld && p2.err)});
    chk("resp_data",  resp_data, (!rst && p2.vld) ? p2.data : 64'd0);
    if (est) gold[widx] = d[g];
    if (rst) clear_model();
    else begin
      p2 = p1;
      p1 = '{vld: (g >= 0), id: (g >= 0) ? g : 0, err: e, data: rdat};
      if (g >= 0) ptr_m = (g + 1) % N;
      last_g = g;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (last_g >= 0) v[last_g] = 0;
    last_g = -1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < N; i++) v[i] = 0;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic [63:0] w0;
    int cnt [N];

    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1110, 4'b0010};
    tbl[2]  = '{4'b1100, 4'b0100};
    tbl[3]  = '{4'b1010, 4'b1000};
    tbl[4]  = '{4'b1010, 4'b0010};
    tbl[5]  = '{4'b1000, 4'b1000};
    tbl[6]  = '{4'b0000, 4'b0000};
    tbl[7]  = '{4'b0110, 4'b0010};
    tbl[8]  = '{4'b0101, 4'b0100};
    tbl[9]  = '{4'b0001, 4'b0001};
    tbl[10] = '{4'b1001, 4'b1000};
    tbl[11] = '{4'b0001, 4'b0001};

    for (int i = 0; i < 512; i++) begin
      bram[i] = {$urandom, $urandom};
      gold[i] = bram[i];
    end
    for (int i = 0; i < N; i++) begin
      v[i] = 0; w[i] = 0; a[i] = '0; d[i] = '0;
    end
    clear_model();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b0;

    // arbitration table, including the sparse wrap 3 -> 1 -> 3
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) begin
        v[i] = tbl[r].valid[i]; w[i] = 0; a[i] = 32'(8 * (i + 1)); d[i] = '0;
      end
      sample();
      chk("tbl_ready", {60'd0, req_ready}, {60'd0, tbl[r].exp_ready});
      advance();
    end
    idle(2);

    // single load
    bram[5] = 64'hDEADBEEF_00000005;
    gold[5] = 64'hDEADBEEF_00000005;
    v[2] = 1; w[2] = 0; a[2] = 32'h28;
    sample();
    chk("single_ready", {60'd0, req_ready}, 64'h4);
    advance();
    tick();
    sample();
    chk("single_rv",   {60'd0, resp_valid}, 64'h4);
    chk("single_data", resp_data, 64'hDEADBEEF_00000005);
    chk("single_err",  {63'd0, resp_err}, 64'd0);
    advance();
    idle(1);

    // store then load of the same word
    v[0] = 1; w[0] = 1; a[0] = 32'h100; d[0] = 64'h1122334455667788;
    tick();
    v[1] = 1; w[1] = 0; a[1] = 32'h100;
    tick();
    sample();
    chk("st_ack_rv",  {60'd0, resp_valid}, 64'h1);
    chk("st_ack_dat", resp_data, 64'd0);
    advance();
    sample();
    chk("ld_new_rv",  {60'd0, resp_valid}, 64'h2);
    chk("ld_new_dat", resp_data, 64'h1122334455667788);
    advance();
    idle(1);

    // fairness: all four loading continuously from reset
    for (int i = 0; i < N; i++) begin
      v[i] = 1; w[i] = 0; a[i] = 32'(64 + 8 * i); cnt[i] = 0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < N; i++) v[i] = 1;
      sample();
      chk("fair_grant", {60'd0, req_ready}, 64'(1 << (c % N)));
      for (int i = 0; i < N; i++) if (resp_valid[i]) cnt[i]++;
      advance();
    end
    for (int i = 0; i < N; i++) v[i] = 0;
    for (int k = 0; k < 2; k++) begin
      sample();
      for (int i = 0; i < N; i++) if (resp_valid[i]) cnt[i]++;
      advance();
    end
    for (int i = 0; i < N; i++) chk("fair_count", 64'(cnt[i]), 64'd4);

    // error requests: misaligned load, out-of-range store
    w0 = bram[0];
    v[0] = 1; w[0] = 0; a[0] = 32'h0C;
    sample();
    chk("err_ld_en", {63'd0, mem_ld_en}, 64'd0);
    advance();
    v[1] = 1; w[1] = 1; a[1] = 32'h1000; d[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    sample();
    chk("err_st_en", {63'd0, mem_st_en}, 64'd0);
    advance();
    sample();
    chk("err1_rv",  {60'd0, resp_valid}, 64'h1);
    chk("err1_err", {63'd0, resp_err}, 64'd1);
    chk("err1_dat", resp_data, 64'd0);
    advance();
    sample();
    chk("err2_rv",  {60'd0, resp_valid}, 64'h2);
    chk("err2_err", {63'd0, resp_err}, 64'd1);
    chk("err2_dat", resp_data, 64'd0);
    advance();
    chk("err_word0", bram[0], w0);
    idle(1);

    // reset one cycle after a load grant
    v[2] = 1; w[2] = 0; a[2] = 32'h28;
    tick();
    rst = 1'b1;
    v[1] = 1; w[1] = 0; a[1] = 32'h30;
    v[3] = 1; w[3] = 0; a[3] = 32'h38;
    sample();
    chk("rst_ready", {60'd0, req_ready}, 64'd0);
    advance();
    rst = 1'b0;
    sample();
    chk("rst_rv",    {60'd0, resp_valid}, 64'd0);
    chk("rst_first", {60'd0, req_ready}, 64'h2);
    advance();
    sample();
    chk("rst_rv2", {60'd0, resp_valid}, 64'd0);
    advance();
    idle(3);

    // randomized traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          int kind;
          v[i] = 1;
          w[i] = bit'($urandom_range(0, 1));
          d[i] = {$urandom, $urandom};
          kind = int'($urandom_range(0, 9));
          if (kind == 0)      a[i] = 32'($urandom_range(0, 511) * 8 + $urandom_range(1, 7));
          else if (kind == 1) a[i] = 32'(4096 + $urandom_range(0, 1000) * 8);
          else                a[i] = 32'($urandom_range(0, 63) * 8);
        end
      end
      tick();
    end
    rst = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
